// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: joystick directions, engine states
// and default playfield size.
package snake_pkg;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_e;

  localparam int DEF_GRID_W = 32;
  localparam int DEF_GRID_H = 24;

endpackage

// File: rtl/snake_seg_match.sv
// Parallel compare of one grid cell against every live segment of the body.
module snake_seg_match #(
  parameter int MAX_LEN = 16,
  parameter int X_W     = 5,
  parameter int Y_W     = 5
) (
  input  logic [MAX_LEN-1:0][X_W-1:0] seg_x,
  input  logic [MAX_LEN-1:0][Y_W-1:0] seg_y,
  input  logic [X_W-1:0]              pt_x,
  input  logic [Y_W-1:0]              pt_y,
  input  logic [MAX_LEN-1:0]          len_mask,
  input  logic                        excl_tail,
  output logic                        hit
);

  logic [MAX_LEN-1:0] next_mask;
  logic [MAX_LEN-1:0] eff_mask;

  // len_mask is thermometer-coded, so dropping its top set bit (the tail)
  // is the same as AND-ing it with itself shifted down by one.
  always_comb begin
    next_mask = {1'b0, len_mask[MAX_LEN-1:1]};
    eff_mask  = excl_tail ? (len_mask & next_mask) : len_mask;
    hit       = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (eff_mask[i] && (seg_x[i] == pt_x) && (seg_y[i] == pt_y)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/snake_motion_engine.sv
// Snake body engine: one-cell move per game tick, wall/self/food detection,
// and registered cell-occupancy answers for the renderer.
module snake_motion_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int X_W      = 5,
  parameter int Y_W      = 5
) (
  input  logic                             vga_clk,
  input  logic                             rst,
  input  logic                             game_tick,
  input  logic [1:0]                       dir_signal,
  input  logic                             start,
  input  logic [X_W-1:0]                   food_x,
  input  logic [Y_W-1:0]                   food_y,
  input  logic [X_W-1:0]                   qry_x,
  input  logic [Y_W-1:0]                   qry_y,
  output logic                             qry_body,
  output logic                             qry_head,
  output logic [X_W-1:0]                   head_x,
  output logic [Y_W-1:0]                   head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]     length,
  output logic                             eat_pulse,
  output logic                             game_over,
  output logic                             running
);

  localparam int L_W = $clog2(MAX_LEN + 1);

  state_e                      state_q;
  logic [MAX_LEN-1:0][X_W-1:0] seg_x_q;
  logic [MAX_LEN-1:0][Y_W-1:0] seg_y_q;
  logic [MAX_LEN-1:0][X_W-1:0] init_x;
  logic [MAX_LEN-1:0][Y_W-1:0] init_y;
  logic [L_W-1:0]              length_q;
  logic                        tick_q;
  logic                        eat_q, over_q, run_q, qbody_q, qhead_q;

  logic [X_W-1:0]     nxt_x;
  logic [Y_W-1:0]     nxt_y;
  logic               wall, eat, self_hit, qry_hit;
  logic [MAX_LEN-1:0] len_mask;

  always_comb begin
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      init_x[i]   = X_W'(GRID_W / 2 - int'(i));
      init_y[i]   = Y_W'(GRID_H / 2);
      len_mask[i] = (L_W'(i) < length_q);
    end
  end

  always_comb begin
    nxt_x = seg_x_q[0];
    nxt_y = seg_y_q[0];
    wall  = 1'b0;
    case (dir_signal)
      UP: begin
        wall  = (seg_y_q[0] == '0);
        nxt_y = seg_y_q[0] - 1'b1;
      end
      RIGHT: begin
        wall  = (seg_x_q[0] == X_W'(GRID_W - 1));
        nxt_x = seg_x_q[0] + 1'b1;
      end
      DOWN: begin
        wall  = (seg_y_q[0] == Y_W'(GRID_H - 1));
        nxt_y = seg_y_q[0] + 1'b1;
      end
      default: begin
        wall  = (seg_x_q[0] == '0);
        nxt_x = seg_x_q[0] - 1'b1;
      end
    endcase
    eat = (nxt_x == food_x) && (nxt_y == food_y);
  end

  // The tail only vacates its cell when the snake is not growing.
  snake_seg_match #(.MAX_LEN(MAX_LEN), .X_W(X_W), .Y_W(Y_W)) u_collide (
    .seg_x     (seg_x_q),
    .seg_y     (seg_y_q),
    .pt_x      (nxt_x),
    .pt_y      (nxt_y),
    .len_mask  (len_mask),
    .excl_tail (~eat),
    .hit       (self_hit)
  );

  snake_seg_match #(.MAX_LEN(MAX_LEN), .X_W(X_W), .Y_W(Y_W)) u_query (
    .seg_x     (seg_x_q),
    .seg_y     (seg_y_q),
    .pt_x      (qry_x),
    .pt_y      (qry_y),
    .len_mask  (len_mask),
    .excl_tail (1'b0),
    .hit       (qry_hit)
  );

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      seg_x_q  <= init_x;
      seg_y_q  <= init_y;
      length_q <= L_W'(INIT_LEN);
      tick_q   <= 1'b0;
      eat_q    <= 1'b0;
      over_q   <= 1'b0;
      run_q    <= 1'b0;
      qbody_q  <= 1'b0;
      qhead_q  <= 1'b0;
    end else begin
      tick_q  <= game_tick;
      eat_q   <= 1'b0;
      qbody_q <= qry_hit;
      qhead_q <= (seg_x_q[0] == qry_x) && (seg_y_q[0] == qry_y);
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end
        end
        RUN: begin
          if (tick_q) begin
            if (wall || self_hit) begin
              state_q <= DEAD;
              run_q   <= 1'b0;
              over_q  <= 1'b1;
            end else begin
              for (int unsigned i = 1; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
              end
              seg_x_q[0] <= nxt_x;
              seg_y_q[0] <= nxt_y;
              if (eat) begin
                eat_q <= 1'b1;
                if (length_q != L_W'(MAX_LEN)) length_q <= length_q + 1'b1;
              end
            end
          end
        end
        DEAD: begin
          if (start) begin
            seg_x_q  <= init_x;
            seg_y_q  <= init_y;
            length_q <= L_W'(INIT_LEN);
            state_q  <= RUN;
            over_q   <= 1'b0;
            run_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = length_q;
  assign eat_pulse = eat_q;
  assign game_over = over_q;
  assign running   = run_q;
  assign qry_body  = qbody_q;
  assign qry_head  = qhead_q;

endmodule
